// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the register file with write-back scoreboard.
package reg_file_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG0_ADDR = '0;

endpackage

// File: rtl/reg_file_if.sv
// Write, read, issue and busy signals of the register file, grouped for port use.
interface reg_file_if #(
    parameter int unsigned XLEN = reg_file_pkg::XLEN,
    parameter int unsigned AW   = reg_file_pkg::AW
);

    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] rd1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd2;
    logic            iss;
    logic [AW-1:0]   isa;
    logic            busy1;
    logic            busy2;

    modport master (
        output we, wa, wd, ra1, ra2, iss, isa,
        input  rd1, rd2, busy1, busy2
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss, isa,
        output rd1, rd2, busy1, busy2
    );

endinterface

// File: rtl/reg_file_wr_decoder.sv
// Address-to-one-hot enable decoder; register 0 never receives an enable.
module wr_decoder
    import reg_file_pkg::*;
#(
    parameter int unsigned NREG = reg_file_pkg::NREG,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr != AW'(REG0_ADDR))) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with write-through bypass and a
// per-register busy scoreboard for pending write-backs.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN = reg_file_pkg::XLEN,
    parameter int unsigned NREG = reg_file_pkg::NREG
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    localparam int unsigned AW = $clog2(NREG);

    logic [NREG-1:0] wr_oh;
    logic [NREG-1:0] iss_oh;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [AW-1:0]   ra      [2];
    logic [XLEN-1:0] rd      [2];
    logic            busy_rd [2];

    wr_decoder #(.NREG(NREG), .AW(AW)) u_wr_dec (
        .en     (bus.we),
        .addr   (bus.wa),
        .onehot (wr_oh)
    );

    wr_decoder #(.NREG(NREG), .AW(AW)) u_iss_dec (
        .en     (bus.iss),
        .addr   (bus.isa),
        .onehot (iss_oh)
    );

    // Write-back clears busy first so a same-edge issue to that register wins.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (wr_oh[i]) begin
                regs_d[i] = bus.wd;
            end
        end
        busy_d = (busy_q & ~wr_oh) | iss_oh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        ra[0] = bus.ra1;
        ra[1] = bus.ra2;
    end

    // Bypassed reads report busy only when the same cycle re-issues the register.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd[p]      = '0;
            busy_rd[p] = 1'b0;
            if (!rst && (ra[p] != AW'(REG0_ADDR))) begin
                if (wr_oh[ra[p]]) begin
                    rd[p]      = bus.wd;
                    busy_rd[p] = iss_oh[ra[p]];
                end else begin
                    rd[p]      = regs_q[ra[p]];
                    busy_rd[p] = busy_q[ra[p]];
                end
            end
        end
    end

    assign bus.rd1   = rd[0];
    assign bus.rd2   = rd[1];
    assign bus.busy1 = busy_rd[0];
    assign bus.busy2 = busy_rd[1];

endmodule
